sprite_engine: RTL and testbench

- Per-scanline sprite renderer and writer side of the pixel linebuffer draw port; the display path only reads that linebuffer.
- On each sprite_start pulse it:
  - scans an internal sprite attribute table,
  - fetches pixel rows for sprites that intersect the next display line from the sprite pixel ROM,
  - writes opaque pixels over the tile background already in the draw buffer.
- Sits beside the tile engine in the VGA top level. Host writes the attribute table through the top-level register decoder.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/sprite_engine_if.sv | 34 +++
 rtl/sprite_attr_table.sv | 30 +++
 rtl/sprite_engine.sv | 142 ++++++++++++++
 tb/tb_sprite_engine.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA types: sprite attribute layout, screen geometry, sprite FSM states.
package vga_pkg;

  localparam int H_ACTIVE        = 640;
  localparam int V_TOTAL         = 525;
  localparam int TRANSPARENT_BIT = 15;

  // Bit layout matches the host register word exactly so it can be cast directly.
  typedef struct packed {
    logic       enable;
    logic [1:0] rsvd;
    logic       flip_x;
    logic [7:0] frame;
    logic [9:0] y;
    logic [9:0] x;
  } sprite_attr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_NEXT  = 3'd4
  } sprite_state_e;

endpackage

// File: rtl/sprite_engine_if.sv
// Sprite engine bus: line-start control, host attribute writes, ROM port, linebuffer draw port.
interface sprite_engine_if #(
  parameter int NUM_SPRITES = 16,
  parameter int FRAME_BITS  = 8
);
  localparam int AW     = $clog2(NUM_SPRITES);
  localparam int ROM_AW = FRAME_BITS + 8;

  logic              sprite_start;
  logic [9:0]        vcount;
  logic              attr_we;
  logic [AW-1:0]     attr_addr;
  logic [31:0]       attr_wdata;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_q;
  logic [9:0]        addr_pixel_draw;
  logic [15:0]       data_pixel_draw;
  logic              wren_pixel_draw;
  logic              sprite_done;
  logic              sprite_busy;

  modport master (
    input  sprite_start, vcount, attr_we, attr_addr, attr_wdata, rom_q,
    output rom_addr, addr_pixel_draw, data_pixel_draw, wren_pixel_draw,
           sprite_done, sprite_busy
  );

  modport slave (
    output sprite_start, vcount, attr_we, attr_addr, attr_wdata, rom_q,
    input  rom_addr, addr_pixel_draw, data_pixel_draw, wren_pixel_draw,
           sprite_done, sprite_busy
  );

endinterface

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: synchronous write, combinational read, cleared on reset.
module sprite_attr_table
  import vga_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int AW          = $clog2(NUM_SPRITES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  sprite_attr_t wdata,
  input  logic [AW-1:0] raddr,
  output sprite_attr_t rdata
);

  sprite_attr_t mem [NUM_SPRITES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A write landing on the entry being read this cycle is seen next cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_engine.sv
// Per-scanline sprite renderer: scans the attribute table, fetches rows from the sprite ROM,
// writes opaque pixels into the linebuffer. Define SPRITE_FLIP_EN to honour attribute flip_x.
module sprite_engine
  import vga_pkg::*;
#(
  parameter int NUM_SPRITES = 16,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int FRAME_BITS  = 8
) (
  input logic             clk,
  input logic             reset,
  sprite_engine_if.master bus
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_READ  = ST_READ;
  localparam logic [2:0] S_FETCH = ST_FETCH;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_NEXT  = ST_NEXT;

  logic [2:0]            state;
  logic [IW-1:0]         idx;
  logic [9:0]            tline;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [CW-1:0]         col_rom;
  logic [FRAME_BITS-1:0] cur_frame;
  logic [9:0]            cur_x;
  logic                  done;
  sprite_attr_t          rd_attr;
  logic [9:0]            dy;
  logic                  hit;
  logic                  unused_bits;

  // Draw-side registers, one cycle behind the ROM address to line up with rom_q.
  logic                  valid_d;
  logic [CW-1:0]         col_d;
  logic [9:0]            x_d;
  logic [10:0]           draw_col;

  sprite_attr_table #(.NUM_SPRITES(NUM_SPRITES), .AW(IW)) u_attr (
    .clk   (clk),
    .reset (reset),
    .we    (bus.attr_we),
    .waddr (bus.attr_addr),
    .wdata (sprite_attr_t'(bus.attr_wdata)),
    .raddr (idx),
    .rdata (rd_attr)
  );

  // 10-bit wrap makes sprites above the line look far away rather than negative.
  assign dy  = tline - rd_attr.y;
  assign hit = rd_attr.enable && (dy < 10'(SPRITE_H));

`ifdef SPRITE_FLIP_EN
  logic cur_flip;
  assign col_rom     = cur_flip ? ~col : col;
  assign unused_bits = ^rd_attr.rsvd;
`else
  assign col_rom     = col;
  assign unused_bits = ^{rd_attr.rsvd, rd_attr.flip_x};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      tline     <= '0;
      row       <= '0;
      col       <= '0;
      cur_frame <= '0;
      cur_x     <= '0;
      done      <= 1'b0;
`ifdef SPRITE_FLIP_EN
      cur_flip  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.sprite_start) begin
          idx   <= IW'(NUM_SPRITES - 1);
          done  <= 1'b0;
          tline <= (bus.vcount == 10'(V_TOTAL - 1)) ? 10'd0 : bus.vcount + 10'd1;
          state <= S_READ;
        end
        S_READ: begin
          cur_frame <= rd_attr.frame[FRAME_BITS-1:0];
          cur_x     <= rd_attr.x;
          row       <= dy[RW-1:0];
          col       <= '0;
`ifdef SPRITE_FLIP_EN
          cur_flip  <= rd_attr.flip_x;
`endif
          state     <= hit ? S_FETCH : S_NEXT;
        end
        S_FETCH: begin
          col <= col + CW'(1);
          if (col == CW'(SPRITE_W - 1)) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_NEXT;
        S_NEXT: begin
          if (idx == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            idx   <= idx - IW'(1);
            state <= S_READ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_d <= 1'b0;
      col_d   <= '0;
      x_d     <= '0;
    end else begin
      valid_d <= (state == S_FETCH);
      col_d   <= col;
      x_d     <= cur_x;
    end
  end

  // 11-bit sum so columns past the right edge clip instead of wrapping to the left.
  assign draw_col = {1'b0, x_d} + {{(11 - CW){1'b0}}, col_d};

  assign bus.rom_addr        = (state == S_FETCH) ? {cur_frame, row, col_rom} : '0;
  assign bus.wren_pixel_draw = valid_d && !bus.rom_q[TRANSPARENT_BIT] &&
                               (draw_col < 11'(H_ACTIVE));
  assign bus.addr_pixel_draw = draw_col[9:0];
  assign bus.data_pixel_draw = valid_d ? bus.rom_q : 16'h0000;
  assign bus.sprite_done     = done;
  assign bus.sprite_busy     = (state != S_IDLE);

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: ROM model, write capture, per-line reference model.
module tb_sprite_engine;
  import vga_pkg::*;

  localparam int NS = 16;
`ifdef SPRITE_FLIP_EN
  localparam bit FLIP_ON = 1'b1;
`else
  localparam bit FLIP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  sprite_engine_if #(.NUM_SPRITES(NS), .FRAME_BITS(8)) bus ();

  sprite_engine #(.NUM_SPRITES(NS), .SPRITE_W(16), .SPRITE_H(16), .FRAME_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rom_mode = 0;
  sprite_attr_t tbl [NS];
  logic [25:0] exp_q [$];
  logic [25:0] got_q [$];
  bit capture = 1'b0;

  // Pixel carries its own address so frame/row/column selection is visible in the data.
  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    case (rom_mode)
      1:       rom_fn = {(a[1:0] == 2'b11), a[14:0]};
      2:       rom_fn = {a[0] ^ a[5] ^ a[9] ^ a[13], a[14:0] ^ 15'h2a5a};
      default: rom_fn = {1'b0, a[14:0]};
    endcase
  endfunction

  always @(posedge clk) bus.rom_q <= rom_fn(bus.rom_addr);

  always @(negedge clk)
    if (capture && bus.wren_pixel_draw)
      got_q.push_back({bus.addr_pixel_draw, bus.data_pixel_draw});

  function automatic sprite_attr_t mk(input bit en, input bit fl, input int fr, input int y, input int x);
    sprite_attr_t a;
    a = '0;
    a.enable = en; a.flip_x = fl; a.frame = 8'(fr); a.y = 10'(y); a.x = 10'(x);
    return a;
  endfunction

  task automatic wr_attr(input int i, input sprite_attr_t a);
    @(negedge clk);
    bus.attr_we = 1'b1; bus.attr_addr = 4'(i); bus.attr_wdata = a;
    @(negedge clk);
    bus.attr_we = 1'b0;
    tbl[i] = a;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NS; i++) wr_attr(i, '0);
  endtask

  // Reference: walk sprites high index to low, emit every visible opaque pixel in order.
  task automatic build_expected(input logic [9:0] vc);
    logic [9:0] tl, dy;
    logic [15:0] a, p;
    int rc, s;
    exp_q.delete();
    tl = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
    for (int i = NS - 1; i >= 0; i--) begin
      dy = tl - tbl[i].y;
      if (tbl[i].enable && dy < 10'd16) begin
        for (int c = 0; c < 16; c++) begin
          rc = (FLIP_ON && tbl[i].flip_x) ? 15 - c : c;
          a  = {tbl[i].frame, dy[3:0], 4'(rc)};
          p  = rom_fn(a);
          s  = int'(tbl[i].x) + c;
          if (!p[15] && s < 640) exp_q.push_back({10'(s), p});
        end
      end
    end
  endtask

  task automatic run_line(input logic [9:0] vc, input int restart_at, input string nm, output int lat);
    int bad;
    build_expected(vc);
    got_q.delete();
    capture = 1'b1;
    @(negedge clk);
    bus.vcount = vc; bus.sprite_start = 1'b1;
    @(negedge clk);
    bus.sprite_start = 1'b0;
    lat = 1;
    while (bus.sprite_done !== 1'b1 && lat < 400) begin
      bus.sprite_start = (lat == restart_at);
      @(negedge clk);
      lat++;
    end
    bus.sprite_start = 1'b0;
    capture = 1'b0;
    n_checks++;
    if (bus.sprite_done !== 1'b1) $display("FAIL %s done_timeout: got done=%b after %0d cycles", nm, bus.sprite_done, lat);
    else n_pass++;
    n_checks++;
    if (lat > 305) $display("FAIL %s latency: got %0d want <=305", nm, lat);
    else n_pass++;
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL %s write_count: got %0d want %0d", nm, got_q.size(), exp_q.size());
    else n_pass++;
    bad = -1;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    n_checks++;
    if (bad >= 0) $display("FAIL %s write_content[%0d]: got col=%0d data=%h want col=%0d data=%h",
                           nm, bad, got_q[bad][25:16], got_q[bad][15:0], exp_q[bad][25:16], exp_q[bad][15:0]);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.sprite_busy, bus.sprite_done, bus.wren_pixel_draw, bus.rom_addr, bus.addr_pixel_draw, bus.data_pixel_draw} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b wren=%b rom=%h addr=%0d data=%h want all 0",
               bus.sprite_busy, bus.sprite_done, bus.wren_pixel_draw, bus.rom_addr, bus.addr_pixel_draw, bus.data_pixel_draw);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.sprite_busy !== 1'b0) $display("FAIL reset_idle: got busy=%b want 0", bus.sprite_busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat;
    rom_mode = 0;
    clear_all();
    wr_attr(0, mk(1, 0, 2, 50, 100));
    run_line(10'd49, -1, "basic", lat);
    n_checks++;
    if (got_q.size() != 16 || got_q[0] !== {10'd100, 16'h0200} || got_q[15] !== {10'd115, 16'h020F})
      $display("FAIL basic_span: got n=%0d first=%h want n=16 first=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 26'h0, {10'd100, 16'h0200});
    else n_pass++;
    n_checks++;
    if (lat != 50) $display("FAIL basic_latency: got %0d want 50", lat);
    else n_pass++;
    // done stays high until the next start
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.sprite_done !== 1'b1 || bus.sprite_busy !== 1'b0)
      $display("FAIL done_hold: got done=%b busy=%b want 1 0", bus.sprite_done, bus.sprite_busy);
    else n_pass++;
  endtask

  task automatic test_miss();
    int lat;
    run_line(10'd65, -1, "miss", lat);
    n_checks++;
    if (got_q.size() != 0 || lat != 33) $display("FAIL miss_scan: got n=%0d lat=%0d want 0 33", got_q.size(), lat);
    else n_pass++;
  endtask

  task automatic test_clip();
    int lat;
    clear_all();
    wr_attr(0, mk(1, 0, 2, 50, 630));
    run_line(10'd49, -1, "clip", lat);
    n_checks++;
    if (got_q.size() != 10 || got_q[got_q.size()-1][25:16] !== 10'd639)
      $display("FAIL clip_count: got n=%0d want 10 ending at 639", got_q.size());
    else n_pass++;
  endtask

  task automatic test_transparent();
    int lat, badc;
    rom_mode = 1;
    clear_all();
    wr_attr(0, mk(1, 0, 2, 50, 100));
    run_line(10'd49, -1, "transp", lat);
    badc = -1;
    foreach (got_q[i]) if ((int'(got_q[i][25:16]) - 100) % 4 == 3) badc = int'(got_q[i][25:16]);
    n_checks++;
    if (got_q.size() != 12 || badc >= 0) $display("FAIL transp_skip: got n=%0d bad_col=%0d want 12 -1", got_q.size(), badc);
    else n_pass++;
    rom_mode = 0;
  endtask

  task automatic test_priority();
    int lat;
    logic [15:0] last;
    clear_all();
    wr_attr(0, mk(1, 0, 5, 10, 200));
    wr_attr(3, mk(1, 0, 9, 10, 200));
    run_line(10'd9, -1, "prio", lat);
    last = 16'hDEAD;
    foreach (got_q[i]) if (got_q[i][25:16] == 10'd200) last = got_q[i][15:0];
    n_checks++;
    if (last !== 16'h0500) $display("FAIL prio_winner: got %h want 0500", last);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int lat;
    clear_all();
    wr_attr(2, mk(1, 0, 1, 0, 300));
    run_line(10'd524, -1, "wrap", lat);
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== {10'd300, 16'h0100})
      $display("FAIL wrap_row0: got n=%0d first=%h want %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 26'h0, {10'd300, 16'h0100});
    else n_pass++;
  endtask

  task automatic test_restart();
    int lat;
    clear_all();
    wr_attr(0, mk(1, 0, 4, 100, 20));
    wr_attr(5, mk(1, 0, 6, 95, 40));
    run_line(10'd100, 10, "restart", lat);
    n_checks++;
    if (lat != 67) $display("FAIL restart_ignored: got latency %0d want 67", lat);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, n;
    clear_all();
    wr_attr(0, mk(1, 0, 2, 50, 100));
    @(negedge clk);
    bus.vcount = 10'd49; bus.sprite_start = 1'b1;
    @(negedge clk);
    bus.sprite_start = 1'b0;
    n = 0;
    while (bus.wren_pixel_draw !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (bus.wren_pixel_draw !== 1'b1) $display("FAIL rstmid_reach_fetch: got wren=%b after %0d cycles want 1", bus.wren_pixel_draw, n);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.wren_pixel_draw, bus.sprite_done, bus.sprite_busy} !== 3'b000)
      $display("FAIL rstmid_abort: got wren=%b done=%b busy=%b want 000", bus.wren_pixel_draw, bus.sprite_done, bus.sprite_busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NS; i++) tbl[i] = '0;
    run_line(10'd49, -1, "rstmid_cleared", lat);
  endtask

  task automatic test_flip();
    int lat;
    logic [15:0] want;
    clear_all();
    wr_attr(1, mk(1, 1, 3, 20, 50));
    run_line(10'd19, -1, "flip", lat);
    want = FLIP_ON ? 16'h030F : 16'h0300;
    n_checks++;
    if (got_q.size() == 0 || got_q[0] !== {10'd50, want})
      $display("FAIL flip_first: got %h want %h", (got_q.size() > 0) ? got_q[0] : 26'h0, {10'd50, want});
    else n_pass++;
  endtask

  task automatic test_random();
    int lat;
    logic [9:0] vc, tl;
    rom_mode = 2;
    for (int it = 0; it < 4; it++) begin
      vc = (it == 3) ? 10'd524 : 10'($urandom_range(0, 524));
      tl = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
      for (int i = 0; i < NS; i++)
        wr_attr(i, mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 255),
                      int'(10'(tl - 10'($urandom_range(0, 20)))), $urandom_range(0, 639)));
      run_line(vc, -1, $sformatf("random%0d", it), lat);
    end
    rom_mode = 0;
  endtask

  initial begin
    bus.sprite_start = 1'b0;
    bus.vcount = '0;
    bus.attr_we = 1'b0;
    bus.attr_addr = '0;
    bus.attr_wdata = '0;
    for (int i = 0; i < NS; i++) tbl[i] = '0;
    test_reset();
    test_basic();
    test_miss();
    test_clip();
    test_transparent();
    test_priority();
    test_wrap();
    test_restart();
    test_reset_mid();
    test_flip();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
